csla_carry_resolver: RTL and testbench

//  Consumer end of the carry-select segment interface. Upstream segment adders deliver
//  a dual-sum pair per segment: sum assuming carry-in 0, and sum assuming carry-in 1.

---
 rtl/csla_carry_resolver.sv | 101 ++++++++++
 tb/tb_csla_carry_resolver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csla_carry_resolver.sv
// Carry-select resolver: one segment resolved per pipeline stage under a global ready/valid advance.
// Optional macro CSLA_SAT_EN saturates the sum field to all ones when the final carry is set.
module csla_carry_resolver #(
  parameter int unsigned SEG_W = 10,
  parameter int unsigned NSEG  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_cin,
  input  logic [NSEG*(SEG_W+1)-1:0] i_sum_0,
  input  logic [NSEG*(SEG_W+1)-1:0] i_sum_1,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NSEG*SEG_W:0]       o_sum
);

  localparam int unsigned PW = SEG_W + 1;

  logic adv;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // Stage k keeps resolved segs 0..k, carry c_{k+1}, and raw pairs of segs k+1..NSEG-1 (NSEG >= 2)
  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int unsigned ResW = (k + 1) * SEG_W;

    logic            vld_in, cin_k, vld_q, cry_q;
    logic [PW-1:0]   p0, p1, sel;
    logic [ResW-1:0] res_d, res_nxt, res_q;

    if (k == 0) begin : g_src
      assign vld_in = i_valid;
      assign cin_k  = i_cin;
      assign p0     = i_sum_0[PW-1:0];
      assign p1     = i_sum_1[PW-1:0];
      assign res_d  = sel[SEG_W-1:0];
    end else begin : g_src
      assign vld_in = g_stg[k-1].vld_q;
      assign cin_k  = g_stg[k-1].cry_q;
      assign p0     = g_stg[k-1].g_raw.raw0_q[PW-1:0];
      assign p1     = g_stg[k-1].g_raw.raw1_q[PW-1:0];
      assign res_d  = {sel[SEG_W-1:0], g_stg[k-1].res_q};
    end

    assign sel = cin_k ? p1 : p0;

    if (k == NSEG - 1) begin : g_fin
`ifdef CSLA_SAT_EN
      assign res_nxt = sel[SEG_W] ? {ResW{1'b1}} : res_d;
`else
      assign res_nxt = res_d;
`endif
    end else begin : g_fin
      assign res_nxt = res_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        cry_q <= sel[SEG_W];
        res_q <= res_nxt;
      end
    end

    if (k < NSEG - 1) begin : g_raw
      localparam int unsigned RawW = (NSEG - 1 - k) * PW;

      logic [RawW-1:0] raw0_d, raw1_d, raw0_q, raw1_q;

      if (k == 0) begin : g_ld
        assign raw0_d = i_sum_0[NSEG*PW-1:PW];
        assign raw1_d = i_sum_1[NSEG*PW-1:PW];
      end else begin : g_ld
        // Drop the pair just consumed by this stage
        assign raw0_d = g_stg[k-1].g_raw.raw0_q[RawW+PW-1:PW];
        assign raw1_d = g_stg[k-1].g_raw.raw1_q[RawW+PW-1:PW];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          raw0_q <= '0;
          raw1_q <= '0;
        end else if (adv) begin
          raw0_q <= raw0_d;
          raw1_q <= raw1_d;
        end
      end
    end
  end

  assign o_valid = g_stg[NSEG-1].vld_q;
  assign o_sum   = {g_stg[NSEG-1].cry_q, g_stg[NSEG-1].res_q};

endmodule

// File: tb/tb_csla_carry_resolver.sv
// Self-checking bench for csla_carry_resolver (SEG_W=10, NSEG=4); honours CSLA_SAT_EN when defined.
module tb_csla_carry_resolver;

  localparam int SEG_W = 10;
  localparam int NSEG  = 4;
  localparam int PW    = SEG_W + 1;
  localparam int IW    = NSEG * PW;
  localparam int AW    = NSEG * SEG_W;
  localparam int OW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready;
  logic          cin = 1'b0;
  logic [IW-1:0] sum_0 = '0;
  logic [IW-1:0] sum_1 = '0;
  logic          out_valid;
  logic          in_ready = 1'b1;
  logic [OW-1:0] out_sum;

  int checks = 0;
  int failures = 0;

  csla_carry_resolver #(.SEG_W(SEG_W), .NSEG(NSEG)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_cin   (cin),
    .i_sum_0 (sum_0),
    .i_sum_1 (sum_1),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_sum   (out_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] saturate(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    r = v;
`ifdef CSLA_SAT_EN
    if (r[OW-1]) r[OW-2:0] = '1;
`endif
    return r;
  endfunction

  // Consistent pairs built from two operands: expected result is plain A + B + cin
  task automatic gen_arith(output logic c, output logic [IW-1:0] s0, output logic [IW-1:0] s1,
                           output logic [OW-1:0] e);
    logic [63:0]   ra, rb;
    logic [31:0]   rc;
    logic [AW-1:0] a, b;
    logic [PW-1:0] t;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    rc = $urandom;
    a  = ra[AW-1:0];
    b  = rb[AW-1:0];
    c  = rc[0];
    for (int k = 0; k < NSEG; k++) begin
      t = {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, b[k*SEG_W +: SEG_W]};
      s0[k*PW +: PW] = t;
      s1[k*PW +: PW] = t + PW'(1);
    end
    e = saturate({1'b0, a} + {1'b0, b} + OW'(c));
  endtask

  // Arbitrary pairs: apply the carry-select rule directly, segment by segment
  function automatic logic [OW-1:0] select_ref(input logic c0, input logic [IW-1:0] s0,
                                               input logic [IW-1:0] s1);
    logic [OW-1:0] r;
    logic [PW-1:0] s;
    logic          c;
    r = '0;
    c = c0;
    for (int k = 0; k < NSEG; k++) begin
      s = c ? s1[k*PW +: PW] : s0[k*PW +: PW];
      r[k*SEG_W +: SEG_W] = s[SEG_W-1:0];
      c = s[SEG_W];
    end
    r[OW-1] = c;
    return saturate(r);
  endfunction

  task automatic drain();
    in_valid = 1'b0;
    in_ready = 1'b1;
    repeat (NSEG + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_sum !== '0) begin
      failures++; $display("FAIL reset_sum: got %h want 0", out_sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", out_ready);
    end
  endtask

  task automatic test_directed();
    logic [OW-1:0] want [2];
    logic          cins [2];
    cins[0] = 1'b1;
`ifdef CSLA_SAT_EN
    want[0] = 41'h1FF_FFFF_FFFF;
`else
    want[0] = 41'h100_0000_0000;
`endif
    cins[1] = 1'b0;
    want[1] = 41'h0FF_FFFF_FFFF;
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c <= NSEG; c++) begin
        in_valid = (c == 0);
        cin      = cins[t];
        sum_0    = {NSEG{11'h3FF}};
        sum_1    = {NSEG{11'h400}};
        #1;
        checks++;
        if (c < NSEG) begin
          if (out_valid !== 1'b0) begin
            failures++; $display("FAIL directed%0d_early c%0d: got valid %b want 0", t, c, out_valid);
          end
        end else if (out_valid !== 1'b1 || out_sum !== want[t]) begin
          failures++;
          $display("FAIL directed%0d_result: got valid %b sum %h want 1 %h", t, out_valid, out_sum,
                   want[t]);
        end
        @(posedge clk); #1;
      end
      drain();
    end
  endtask

  task automatic test_stream(input string name, input logic [7:0] mask);
    logic [OW-1:0] exp_q [8];
    logic          c;
    logic [IW-1:0] a0, a1;
    logic [OW-1:0] e;
    logic          want_v;
    int            j;
    for (int cyc = 0; cyc < 8 + NSEG + 2; cyc++) begin
      in_ready = 1'b1;
      in_valid = 1'b0;
      if (cyc < 8 && mask[cyc]) begin
        gen_arith(c, a0, a1, e);
        cin = c; sum_0 = a0; sum_1 = a1; exp_q[cyc] = e;
        in_valid = 1'b1;
      end
      #1;
      j      = cyc - NSEG;
      want_v = (j >= 0 && j < 8) ? mask[j] : 1'b0;
      checks++;
      if (out_valid !== want_v) begin
        failures++; $display("FAIL %s_valid cyc%0d: got %b want %b", name, cyc, out_valid, want_v);
      end else if (want_v) begin
        checks++;
        if (out_sum !== exp_q[j]) begin
          failures++; $display("FAIL %s_sum set%0d: got %h want %h", name, j, out_sum, exp_q[j]);
        end
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    test_stream("b2b", 8'hFF);
  endtask

  task automatic test_gapped();
    test_stream("gap", 8'h55);
  endtask

  task automatic test_stall();
    logic          cs [6];
    logic [IW-1:0] a0 [6];
    logic [IW-1:0] a1 [6];
    logic [OW-1:0] q [$];
    logic [63:0]   r;
    logic [31:0]   rc;
    int            idx = 0;
    int            got = 0;
    for (int i = 0; i < 6; i++) begin
      r = {$urandom, $urandom}; a0[i] = r[IW-1:0];
      r = {$urandom, $urandom}; a1[i] = r[IW-1:0];
      rc = $urandom; cs[i] = rc[0];
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_ready = (cyc >= NSEG + 5);
      in_valid = (idx < 6);
      if (idx < 6) begin
        cin = cs[idx]; sum_0 = a0[idx]; sum_1 = a1[idx];
      end
      #1;
      if (cyc >= NSEG && cyc < NSEG + 5) begin
        checks++;
        if (out_ready !== 1'b0 || out_valid !== 1'b1 || q.size() == 0 || out_sum !== q[0]) begin
          failures++;
          $display("FAIL stall_hold cyc%0d: got ready %b valid %b sum %h want 0 1 %h", cyc,
                   out_ready, out_valid, out_sum, (q.size() > 0) ? q[0] : '0);
        end
      end
      if (out_valid && in_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stall_extra: got %h want nothing", out_sum);
        end else begin
          if (out_sum !== q[0]) begin
            failures++; $display("FAIL stall_order out%0d: got %h want %h", got, out_sum, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && out_ready) begin
        q.push_back(select_ref(cs[idx], a0[idx], a1[idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 6 || q.size() != 0) begin
      failures++; $display("FAIL stall_count: got %0d outputs want 6", got);
    end
    drain();
  endtask

  task automatic test_reset_flight();
    logic          c;
    logic [IW-1:0] a0, a1;
    logic [OW-1:0] e;
    int            seen = 0;
    in_ready = 1'b0;
    for (int cyc = 0; cyc < NSEG + 1; cyc++) begin
      in_valid = (cyc < 3);
      if (cyc < 3) begin
        gen_arith(c, a0, a1, e);
        cin = c; sum_0 = a0; sum_1 = a1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL flight_pre: got valid %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      failures++; $display("FAIL flight_async: got valid %b sum %h want 0 0", out_valid, out_sum);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_ready = 1'b1;
    repeat (12) begin
      #1;
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL flight_leak: got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_gapped();
    test_stall();
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
